// File: rtl/tia_hcount_lfsr_if.sv
// ---------------------------------------------------------------------------
// tia_hcount_lfsr_if
// Bundles the line-timing signals of tia_hcount_lfsr.
//   rsync      : line-restart level from the controller
//   hmove_clk  : extra-clock request (only when TIA_HCOUNT_EXTRA_CLOCK_EN)
//   s1, s2     : two-phase strobes for the D2 latch stages
//   count      : 6-bit polynomial counter state
//   wrap       : one-clk end-of-line pulse
//   dec_a/b    : position decodes
// Modports: master drives rsync (and hmove_clk), slave drives the strobes.
// ---------------------------------------------------------------------------
interface tia_hcount_lfsr_if;
    logic       rsync;
    logic       s1;
    logic       s2;
    logic [5:0] count;
    logic       wrap;
    logic       dec_a;
    logic       dec_b;
`ifdef TIA_HCOUNT_EXTRA_CLOCK_EN
    logic       hmove_clk;

    modport master (output rsync, output hmove_clk,
                    input s1, input s2, input count, input wrap, input dec_a, input dec_b);
    modport slave  (input rsync, input hmove_clk,
                    output s1, output s2, output count, output wrap, output dec_a, output dec_b);
`else
    modport master (output rsync,
                    input s1, input s2, input count, input wrap, input dec_a, input dec_b);
    modport slave  (input rsync,
                    output s1, output s2, output count, output wrap, output dec_a, output dec_b);
`endif
endinterface

// File: rtl/tia_hcount_lfsr.sv
// ---------------------------------------------------------------------------
// tia_hcount_lfsr
// Horizontal line-timing stage. The colour clock is divided by 4 into
// non-overlapping s1/s2 strobes; a 6-bit XNOR LFSR built as a master (tap)
// and slave (count) stage advances once per s1/s2 pair and wraps after
// WRAP_STEP+1 states.
// Ports:
//   clk    : colour clock, all state on rising edge
//   reset  : synchronous, active-high
//   hc     : tia_hcount_lfsr_if.slave (rsync in; s1, s2, count, wrap,
//            dec_a, dec_b out; hmove_clk in when the option is built)
// Option macro: TIA_HCOUNT_EXTRA_CLOCK_EN adds hmove_clk, which inserts one
// extra s1/s2 pair when pulsed while the phase counter is 3.
// ---------------------------------------------------------------------------
module tia_hcount_lfsr #(
    parameter int WRAP_STEP  = 56,
    parameter int DEC_A_STEP = 4,
    parameter int DEC_B_STEP = 8
) (
    input  logic               clk,
    input  logic               reset,
    tia_hcount_lfsr_if.slave   hc
);

    function automatic logic [5:0] lfsr_next(input logic [5:0] v);
        return {v[4:0], ~(v[5] ^ v[4])};
    endfunction

    // Pattern reached after n shifts from all-zeros; evaluated at elaboration.
    function automatic logic [5:0] step_pattern(input int n);
        logic [5:0] v;
        v = 6'b000000;
        for (int i = 0; i < n; i++) begin
            v = lfsr_next(v);
        end
        return v;
    endfunction

    localparam int              SW        = $clog2(WRAP_STEP + 1);
    localparam logic [5:0]      PAT_A     = step_pattern(DEC_A_STEP);
    localparam logic [5:0]      PAT_B     = step_pattern(DEC_B_STEP);
    localparam logic [SW-1:0]   STEP_LAST = WRAP_STEP[SW-1:0];
    localparam logic [SW-1:0]   STEP_ONE  = 1;

    logic [1:0]    r_ph;
    logic [5:0]    r_tap;
    logic [5:0]    r_count;
    logic [SW-1:0] r_step;
    logic [SW-1:0] r_tap_step;
    logic          r_wrap;
    logic          r_dec_a;
    logic          r_dec_b;

    logic          w_run;
    logic          w_s1;
    logic          w_s2;
    logic [5:0]    w_src;
    logic [SW-1:0] w_src_step;
    logic [5:0]    w_count_nxt;

    assign w_run = ~reset & ~hc.rsync;

`ifdef TIA_HCOUNT_EXTRA_CLOCK_EN
    logic r_pend;
    logic w_xs1;
    logic w_xs2;

    assign w_xs1 = w_run & (r_ph == 2'd3) & hc.hmove_clk;
    assign w_xs2 = w_run & (r_ph == 2'd1) & r_pend;
    assign w_s1  = w_run & ((r_ph == 2'd0) | w_xs1);
    assign w_s2  = w_run & ((r_ph == 2'd2) | w_xs2);
    // The master feeds from the value the slave will hold after its next
    // transfer, so a second s1 before the pending s2 still advances a step.
    assign w_src      = ~r_tap;
    assign w_src_step = r_tap_step;

    always_ff @(posedge clk) begin
        if (reset || hc.rsync) begin
            r_pend <= 1'b0;
        end else if (w_xs1) begin
            r_pend <= 1'b1;
        end else if (w_xs2) begin
            r_pend <= 1'b0;
        end
    end
`else
    assign w_s1       = w_run & (r_ph == 2'd0);
    assign w_s2       = w_run & (r_ph == 2'd2);
    assign w_src      = r_count;
    assign w_src_step = r_step;
`endif

    assign w_count_nxt = w_s2 ? ~r_tap : r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ph       <= 2'd0;
            r_tap      <= 6'b111111;
            r_count    <= 6'b000000;
            r_step     <= '0;
            r_tap_step <= '0;
            r_wrap     <= 1'b0;
            r_dec_a    <= 1'b0;
            r_dec_b    <= 1'b0;
        end else if (hc.rsync) begin
            r_ph       <= 2'd0;
            r_tap      <= 6'b111111;
            r_count    <= 6'b000000;
            r_step     <= '0;
            r_tap_step <= '0;
            r_wrap     <= 1'b0;
            r_dec_a    <= (PAT_A == 6'b000000);
            r_dec_b    <= (PAT_B == 6'b000000);
        end else begin
            r_ph <= r_ph + 2'd1;
            if (w_s1) begin
                if (w_src_step == STEP_LAST) begin
                    r_tap      <= 6'b111111;
                    r_tap_step <= '0;
                end else begin
                    r_tap      <= ~lfsr_next(w_src);
                    r_tap_step <= w_src_step + STEP_ONE;
                end
            end
            if (w_s2) begin
                r_count <= ~r_tap;
                r_step  <= r_tap_step;
            end
            // A transfer that moves the step index backwards is the line wrap.
            r_wrap  <= w_s2 & (r_tap_step < r_step);
            // Decode the value count takes on this edge so the flag lines up
            // with count instead of lagging it by a clock.
            r_dec_a <= (w_count_nxt == PAT_A);
            r_dec_b <= (w_count_nxt == PAT_B);
        end
    end

    assign hc.s1    = w_s1;
    assign hc.s2    = w_s2;
    assign hc.count = r_count;
    assign hc.wrap  = r_wrap;
    assign hc.dec_a = r_dec_a;
    assign hc.dec_b = r_dec_b;

endmodule
